// File: rtl/miriscv_trace_pkg.sv
// Shared types for the RVFI retire-trace buffer: packed retirement entry and field widths.
package miriscv_trace_pkg;

  localparam int XLEN       = 32;
  localparam int ORDER_W    = 64;
  localparam int REG_ADDR_W = 5;
  localparam int MASK_W     = 4;

  typedef struct packed {
    logic [ORDER_W-1:0]    order;
    logic [XLEN-1:0]       insn;
    logic                  trap;
    logic [XLEN-1:0]       pc_rdata;
    logic [XLEN-1:0]       pc_wdata;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [XLEN-1:0]       rd_wdata;
    logic [XLEN-1:0]       mem_addr;
    logic [MASK_W-1:0]     mem_rmask;
    logic [MASK_W-1:0]     mem_wmask;
    logic [XLEN-1:0]       mem_rdata;
    logic [XLEN-1:0]       mem_wdata;
  } rvfi_entry_t;

  localparam int ENTRY_W = $bits(rvfi_entry_t);

endpackage

// File: rtl/miriscv_trace_fifo_mem.sv
// Trace entry storage: DEPTH x ENTRY_W register array, one write port, async read port.
module miriscv_trace_fifo_mem
  import miriscv_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          gclk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  rvfi_entry_t   wdata,
  input  logic [AW-1:0] raddr,
  output rvfi_entry_t   rdata
);

  rvfi_entry_t mem [DEPTH];

  // Data storage is deliberately unreset; validity comes from the pointers.
  always_ff @(posedge gclk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/miriscv_rvfi_trace_buffer.sv
// RVFI retire-trace FIFO with FWFT valid/ready output, drop accounting and occupancy.
// Optional retirement-order checking is built when MIRISCV_TRACE_ORDER_CHECK_EN is defined.
module miriscv_rvfi_trace_buffer
  import miriscv_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     rvfi_valid_i,
  input  logic [ORDER_W-1:0]       rvfi_order_i,
  input  logic [XLEN-1:0]          rvfi_insn_i,
  input  logic                     rvfi_trap_i,
  input  logic [XLEN-1:0]          rvfi_pc_rdata_i,
  input  logic [XLEN-1:0]          rvfi_pc_wdata_i,
  input  logic [REG_ADDR_W-1:0]    rvfi_rd_addr_i,
  input  logic [XLEN-1:0]          rvfi_rd_wdata_i,
  input  logic [XLEN-1:0]          rvfi_mem_addr_i,
  input  logic [MASK_W-1:0]        rvfi_mem_rmask_i,
  input  logic [MASK_W-1:0]        rvfi_mem_wmask_i,
  input  logic [XLEN-1:0]          rvfi_mem_rdata_i,
  input  logic [XLEN-1:0]          rvfi_mem_wdata_i,
  input  logic                     flush_i,
  input  logic                     clear_err_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [ENTRY_W-1:0]       out_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic [CNT_W-1:0]         drop_cnt_o,
  output logic                     order_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          empty, full, pop, push, drop;
  rvfi_entry_t   wr_entry, rd_entry;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign pop  = out_valid_o && out_ready_i;
  assign push = rvfi_valid_i && (!full || pop);
  // A flushed cycle neither moves data nor counts as a drop.
  assign drop = rvfi_valid_i && full && !pop && !flush_i;

  assign wr_entry = '{
    order:     rvfi_order_i,
    insn:      rvfi_insn_i,
    trap:      rvfi_trap_i,
    pc_rdata:  rvfi_pc_rdata_i,
    pc_wdata:  rvfi_pc_wdata_i,
    rd_addr:   rvfi_rd_addr_i,
    rd_wdata:  rvfi_rd_wdata_i,
    mem_addr:  rvfi_mem_addr_i,
    mem_rmask: rvfi_mem_rmask_i,
    mem_wmask: rvfi_mem_wmask_i,
    mem_rdata: rvfi_mem_rdata_i,
    mem_wdata: rvfi_mem_wdata_i
  };

  miriscv_trace_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .gclk  (clk_i),
    .we    (push && !flush_i),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_entry),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_entry)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Same-cycle drop beats clear so the new drop is never lost.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else if (drop) begin
      overflow_o <= 1'b1;
      if (clear_err_i)            drop_cnt_o <= {{(CNT_W-1){1'b0}}, 1'b1};
      else if (drop_cnt_o != '1)  drop_cnt_o <= drop_cnt_o + 1'b1;
    end else if (clear_err_i) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end
  end

  assign out_valid_o = !empty;
  assign out_data_o  = empty ? {ENTRY_W{1'b0}} : rd_entry;
  assign count_o     = wr_ptr - rd_ptr;

`ifdef MIRISCV_TRACE_ORDER_CHECK_EN
  logic [ORDER_W-1:0] last_order;
  logic               first_seen;
  logic               order_bad;

  assign order_bad = rvfi_valid_i && first_seen && (rvfi_order_i != last_order + 64'd1);

  // Tracking follows every retirement, dropped or flushed, and only reset restarts it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_order  <= '0;
      first_seen  <= 1'b0;
      order_err_o <= 1'b0;
    end else begin
      if (rvfi_valid_i) begin
        last_order <= rvfi_order_i;
        first_seen <= 1'b1;
      end
      if (order_bad)        order_err_o <= 1'b1;
      else if (clear_err_i) order_err_o <= 1'b0;
    end
  end
`else
  assign order_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_miriscv_rvfi_trace_buffer.sv
// Scoreboard bench for the RVFI trace buffer: stimulus queues expected entries, a negedge monitor checks pops.
module tb_miriscv_rvfi_trace_buffer;
  import miriscv_trace_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNT_W = 16;
  localparam int PW    = $clog2(DEPTH) + 1;

`ifdef MIRISCV_TRACE_ORDER_CHECK_EN
  localparam logic ORDER_EXP = 1'b1;
`else
  localparam logic ORDER_EXP = 1'b0;
`endif

  logic clk_i = 1'b0, rst_i = 1'b1;
  logic rvfi_valid_i = 1'b0, rvfi_trap_i = 1'b0;
  logic [63:0] rvfi_order_i = '0;
  logic [31:0] rvfi_insn_i = '0, rvfi_pc_rdata_i = '0, rvfi_pc_wdata_i = '0, rvfi_rd_wdata_i = '0;
  logic [31:0] rvfi_mem_addr_i = '0, rvfi_mem_rdata_i = '0, rvfi_mem_wdata_i = '0;
  logic [4:0]  rvfi_rd_addr_i = '0;
  logic [3:0]  rvfi_mem_rmask_i = '0, rvfi_mem_wmask_i = '0;
  logic flush_i = 1'b0, clear_err_i = 1'b0, out_ready_i = 1'b0;
  logic out_valid_o, overflow_o, order_err_o;
  logic [ENTRY_W-1:0] out_data_o;
  logic [PW-1:0]      count_o;
  logic [CNT_W-1:0]   drop_cnt_o;
  rvfi_entry_t od;

  int vectors = 0;
  int miscompares = 0;
  rvfi_entry_t q[$];

  assign od = out_data_o;

  always #5 clk_i = ~clk_i;

  miriscv_rvfi_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rvfi_valid_i(rvfi_valid_i), .rvfi_order_i(rvfi_order_i), .rvfi_insn_i(rvfi_insn_i),
    .rvfi_trap_i(rvfi_trap_i), .rvfi_pc_rdata_i(rvfi_pc_rdata_i), .rvfi_pc_wdata_i(rvfi_pc_wdata_i),
    .rvfi_rd_addr_i(rvfi_rd_addr_i), .rvfi_rd_wdata_i(rvfi_rd_wdata_i),
    .rvfi_mem_addr_i(rvfi_mem_addr_i), .rvfi_mem_rmask_i(rvfi_mem_rmask_i),
    .rvfi_mem_wmask_i(rvfi_mem_wmask_i), .rvfi_mem_rdata_i(rvfi_mem_rdata_i),
    .rvfi_mem_wdata_i(rvfi_mem_wdata_i), .flush_i(flush_i), .clear_err_i(clear_err_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .count_o(count_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o), .order_err_o(order_err_o)
  );

  function automatic rvfi_entry_t mk(input logic [63:0] ord);
    rvfi_entry_t e;
    e.order     = ord;
    e.insn      = 32'h0000_0013 ^ (ord[31:0] << 7);
    e.trap      = ord[0];
    e.pc_rdata  = 32'h8000_0000 + (ord[31:0] << 2);
    e.pc_wdata  = 32'h8000_0004 + (ord[31:0] << 2);
    e.rd_addr   = ord[4:0];
    e.rd_wdata  = ~ord[31:0];
    e.mem_addr  = 32'h1000_0000 | ord[31:0];
    e.mem_rmask = ord[3:0];
    e.mem_wmask = ~ord[3:0];
    e.mem_rdata = 32'hA5A5_0000 | ord[31:0];
    e.mem_wdata = 32'h5A5A_0000 | ord[31:0];
    return e;
  endfunction

  task automatic drive(input rvfi_entry_t e);
    rvfi_order_i = e.order;        rvfi_insn_i = e.insn;          rvfi_trap_i = e.trap;
    rvfi_pc_rdata_i = e.pc_rdata;  rvfi_pc_wdata_i = e.pc_wdata;  rvfi_rd_addr_i = e.rd_addr;
    rvfi_rd_wdata_i = e.rd_wdata;  rvfi_mem_addr_i = e.mem_addr;  rvfi_mem_rmask_i = e.mem_rmask;
    rvfi_mem_wmask_i = e.mem_wmask; rvfi_mem_rdata_i = e.mem_rdata; rvfi_mem_wdata_i = e.mem_wdata;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // n back-to-back retirements starting at order first; only the first nq are expected to be kept.
  task automatic push_seq(input logic [63:0] first, input int n, input int nq);
    for (int i = 0; i < n; i++) begin
      drive(mk(first + 64'(i)));
      rvfi_valid_i = 1'b1;
      if (i < nq) q.push_back(mk(first + 64'(i)));
      @(posedge clk_i); #1;
    end
    rvfi_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; rvfi_valid_i = 1'b0; out_ready_i = 1'b0; flush_i = 1'b0; clear_err_i = 1'b0;
    q.delete();
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    out_ready_i = 1'b1;
    while (out_valid_o && n < max_cyc) begin
      @(posedge clk_i); #1;
      n++;
    end
    out_ready_i = 1'b0;
    chk("drain_valid_low", 64'(out_valid_o), 64'd0);
    chk("drain_queue_empty", 64'(q.size()), 64'd0);
  endtask

  // Monitor: a handshake seen at negedge completes on the following posedge.
  logic        held = 1'b0;
  rvfi_entry_t held_data;
  always @(negedge clk_i) begin
    if (rst_i || flush_i) begin
      held = 1'b0;
    end else if (out_valid_o && out_ready_i) begin
      held = 1'b0;
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL pop_unexpected: got order %0d with empty scoreboard", od.order);
      end else begin
        rvfi_entry_t e;
        e = q.pop_front();
        if (od !== e) begin
          miscompares++;
          $display("FAIL pop_entry: got order %0d insn %h expected order %0d insn %h",
                   od.order, od.insn, e.order, e.insn);
        end
      end
    end else if (out_valid_o) begin
      if (held) begin
        vectors++;
        if (od !== held_data) begin
          miscompares++;
          $display("FAIL head_stable: got order %0d expected %0d", od.order, held_data.order);
        end
      end
      held = 1'b1;
      held_data = od;
    end else begin
      held = 1'b0;
    end
  end

  initial begin
    // Reset state and basic FWFT with backpressure
    do_reset();
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_overflow", 64'(overflow_o), 64'd0);
    chk("rst_drop", 64'(drop_cnt_o), 64'd0);
    chk("rst_order_err", 64'(order_err_o), 64'd0);
    chk("rst_data", 64'(|out_data_o), 64'd0);
    push_seq(64'd0, 3, 3);
    chk("t1_count", 64'(count_o), 64'd3);
    chk("t1_head", od.order, 64'd0);
    repeat (2) @(posedge clk_i);
    #1 chk("t1_head_held", od.order, 64'd0);
    drain(10);

    // Overflow: 18 into 16
    do_reset();
    push_seq(64'd0, 18, 16);
    chk("t2_count", 64'(count_o), 64'd16);
    chk("t2_overflow", 64'(overflow_o), 64'd1);
    chk("t2_drop", 64'(drop_cnt_o), 64'd2);
    drain(40);

    // Full with simultaneous push and pop
    do_reset();
    push_seq(64'd0, 16, 16);
    drive(mk(64'd16));
    rvfi_valid_i = 1'b1; out_ready_i = 1'b1;
    q.push_back(mk(64'd16));
    @(posedge clk_i); #1;
    rvfi_valid_i = 1'b0; out_ready_i = 1'b0;
    chk("t3_count", 64'(count_o), 64'd16);
    chk("t3_drop", 64'(drop_cnt_o), 64'd0);
    chk("t3_overflow", 64'(overflow_o), 64'd0);
    chk("t3_head", od.order, 64'd1);
    drain(40);

    // Flush with simultaneous push, then clear_err and drop-beats-clear
    do_reset();
    push_seq(64'd0, 17, 16);
    drive(mk(64'd17));
    rvfi_valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk_i); #1;
    rvfi_valid_i = 1'b0; flush_i = 1'b0;
    q.delete();
    chk("t4_count", 64'(count_o), 64'd0);
    chk("t4_valid", 64'(out_valid_o), 64'd0);
    chk("t4_overflow_kept", 64'(overflow_o), 64'd1);
    chk("t4_drop_kept", 64'(drop_cnt_o), 64'd1);
    clear_err_i = 1'b1;
    @(posedge clk_i); #1;
    clear_err_i = 1'b0;
    chk("t4_clr_overflow", 64'(overflow_o), 64'd0);
    chk("t4_clr_drop", 64'(drop_cnt_o), 64'd0);
    push_seq(64'd18, 16, 16);
    drive(mk(64'd34));
    rvfi_valid_i = 1'b1; clear_err_i = 1'b1;
    @(posedge clk_i); #1;
    rvfi_valid_i = 1'b0; clear_err_i = 1'b0;
    chk("t4_drop_wins_flag", 64'(overflow_o), 64'd1);
    chk("t4_drop_wins_cnt", 64'(drop_cnt_o), 64'd1);
    drain(40);

    // Order check: 7, 8, 10
    do_reset();
    out_ready_i = 1'b1;
    push_seq(64'd7, 2, 2);
    chk("t5_order_ok", 64'(order_err_o), 64'd0);
    push_seq(64'd10, 1, 1);
    chk("t5_order_err", 64'(order_err_o), 64'(ORDER_EXP));
    drain(10);

    // Asynchronous reset mid-stream, then a fresh push
    do_reset();
    push_seq(64'd0, 9, 9);
    chk("t6_count9", 64'(count_o), 64'd9);
    #1 rst_i = 1'b1;
    q.delete();
    #1;
    chk("t6_async_valid", 64'(out_valid_o), 64'd0);
    chk("t6_async_count", 64'(count_o), 64'd0);
    chk("t6_async_data", 64'(|out_data_o), 64'd0);
    #5 rst_i = 1'b0;
    @(posedge clk_i); #1;
    push_seq(64'd100, 1, 1);
    chk("t6_post_valid", 64'(out_valid_o), 64'd1);
    chk("t6_post_count", 64'(count_o), 64'd1);
    drain(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
